// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column at a time, synchronizes and
// accumulates the row sense lines, debounces full scans, and emits a hex key code.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter logic        ACTIVE_LOW     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [3:0] ROW_IDLE = ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAND,
        S_PRESSED,
        S_REL
    } state_e;

    // Column drive pattern for a given column index, in pin polarity.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        return ACTIVE_LOW ? ~oh : oh;
    endfunction

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       acc_n_q, acc_n_d;
    logic [3:0]       acc_code_q, acc_code_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             multi_q, multi_d;

    logic [3:0]       pressed;
    logic [2:0]       hits;
    logic [1:0]       row_idx;
    logic [2:0]       total;
    logic [1:0]       scan_n;
    logic [3:0]       scan_code;
    logic             single;
    logic             none;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= ROW_IDLE;
            sync2_q     <= ROW_IDLE;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= col_drive(2'd0);
            acc_n_q     <= 2'd0;
            acc_code_q  <= 4'd0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            acc_n_q     <= acc_n_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_q     <= multi_d;
        end
    end

    always_comb begin
        sync1_d     = row;
        sync2_d     = sync1_q;
        div_d       = div_q;
        col_idx_d   = col_idx_q;
        col_d       = col_q;
        acc_n_d     = acc_n_q;
        acc_code_d  = acc_code_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        multi_d     = multi_q;

        // Running scan result: saturating hit count plus the code of the lone hit.
        pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;
        hits    = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pressed[i]) row_idx = 2'(i);
        end
        total     = 3'(acc_n_q) + hits;
        scan_n    = (total >= 3'd2) ? 2'd2 : total[1:0];
        scan_code = (hits != 3'd0) ? {row_idx, col_idx_q} : acc_code_q;
        single    = (scan_n == 2'd1);
        none      = (scan_n == 2'd0);
        cnt_inc   = cnt_q + CNT_W'(1);

        if (div_q == DIV_LAST) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = col_drive(col_idx_q + 2'd1);
            if (col_idx_q == 2'd3) begin
                acc_n_d    = 2'd0;
                acc_code_d = 4'd0;
                multi_d    = (scan_n == 2'd2);
                unique case (state_q)
                    S_IDLE: begin
                        if (single) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state_d     = S_PRESSED;
                                key_d       = scan_code;
                                key_valid_d = 1'b1;
                                key_held_d  = 1'b1;
                            end else begin
                                state_d = S_CAND;
                                cand_d  = scan_code;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                    end
                    S_CAND: begin
                        if (single && (scan_code == cand_q)) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                state_d     = S_PRESSED;
                                key_d       = cand_q;
                                key_valid_d = 1'b1;
                                key_held_d  = 1'b1;
                                cnt_d       = '0;
                            end
                        end else if (single) begin
                            cand_d = scan_code;
                            cnt_d  = CNT_W'(1);
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    S_PRESSED: begin
                        if (none) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state_d    = S_IDLE;
                                key_held_d = 1'b0;
                            end else begin
                                state_d = S_REL;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                    end
                    S_REL: begin
                        if (none) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                state_d    = S_IDLE;
                                key_held_d = 1'b0;
                                cnt_d      = '0;
                            end
                        end else begin
                            // Key came back before release settled: resume the hold silently.
                            state_d = S_PRESSED;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end else begin
                acc_n_d    = scan_n;
                acc_code_d = scan_code;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a behavioural key matrix drives the rows of a
// default instance and of an active-high, fast-scan instance.
module tb_keypad_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  col1, row1, key1;
    logic        kv1, kh1, m1;
    logic [3:0]  col2, row2, key2;
    logic        kv2, kh2, m2;
    logic [15:0] pk1, pk2;

    int n_tests = 0;
    int n_fail  = 0;
    int np1 = 0, np2 = 0;
    int consec = 0;
    logic [3:0] lk1, lk2;
    logic pv1 = 1'b0, pv2 = 1'b0;
    int base;

    keypad_scan u_dut (
        .clk(clk), .rst(rst), .col(col1), .row(row1),
        .key(key1), .key_valid(kv1), .key_held(kh1), .multi(m1)
    );

    keypad_scan #(.SCAN_DIV(3), .DEBOUNCE_SCANS(1), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .col(col2), .row(row2),
        .key(key2), .key_valid(kv2), .key_held(kh2), .multi(m2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key matrix: pk[r*4+c] closes row r to column c.
    always_comb begin
        row1 = 4'hF;
        row2 = 4'h0;
        for (int r = 0; r < 4; r++) begin
            row1[r] = ~|(pk1[r*4 +: 4] & ~col1);
            row2[r] = |(pk2[r*4 +: 4] & col2);
        end
    end

    // Pulse monitor, reads pre-edge output values.
    always @(posedge clk) begin
        if (kv1) begin
            np1 = np1 + 1;
            lk1 = key1;
            if (pv1) consec = consec + 1;
        end
        if (kv2) begin
            np2 = np2 + 1;
            lk2 = key2;
            if (pv2) consec = consec + 1;
        end
        pv1 = kv1;
        pv2 = kv2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pulse(input bit which, input int max_cyc, input string tag);
        int b;
        int n;
        b = which ? np2 : np1;
        n = 0;
        while (((which ? np2 : np1) == b) && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'((which ? np2 : np1) != b), 32'd1);
    endtask

    task automatic wait_release(input bit which, input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((which ? kh2 : kh1) && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(which ? kh2 : kh1), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        pk1 = 16'h0;
        pk2 = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col1), 32'hE);
        check("rst_key", 32'(key1), 32'h0);
        check("rst_outs", 32'({kv1, kh1, m1}), 32'h0);
        check("rst_col_hi", 32'(col2), 32'h1);
        rst = 1'b0;

        // Clean press of row 2 / column 1.
        pk1 = 16'h0200;
        base = np1;
        wait_pulse(1'b0, 70, "press_pulse");
        @(negedge clk);
        check("press_key", 32'(key1), 32'h9);
        check("press_held", 32'(kh1), 32'd1);
        repeat (130) @(negedge clk);
        check("press_once", 32'(np1 - base), 32'd1);
        pk1 = 16'h0;
        repeat (30) @(negedge clk);
        check("held_during_rel", 32'(kh1), 32'd1);
        wait_release(1'b0, 45, "release_drop");
        check("key_kept", 32'(key1), 32'h9);

        // Bouncing row 0 / column 0.
        base = np1;
        pk1 = 16'h0001;
        for (int i = 0; i < 30; i++) begin
            repeat (5) @(negedge clk);
            pk1[0] = ~pk1[0];
        end
        check("bounce_quiet", 32'(np1 - base), 32'd0);
        pk1 = 16'h0001;
        wait_pulse(1'b0, 70, "bounce_pulse");
        check("bounce_key", 32'(lk1), 32'h0);
        pk1 = 16'h0;
        wait_release(1'b0, 80, "bounce_rel");

        // Two keys together, then one let go.
        pk1 = 16'h4010;
        repeat (40) @(negedge clk);
        check("multi_set", 32'(m1), 32'd1);
        base = np1;
        repeat (100) @(negedge clk);
        check("multi_no_pulse", 32'(np1 - base), 32'd0);
        check("multi_no_held", 32'(kh1), 32'd0);
        pk1[14] = 1'b0;
        wait_pulse(1'b0, 70, "multi_single_pulse");
        check("multi_single_key", 32'(lk1), 32'h4);
        @(negedge clk);
        check("multi_clear", 32'(m1), 32'd0);
        pk1 = 16'h0;
        wait_release(1'b0, 80, "multi_rel");

        // Long hold, full release and re-press, short release.
        base = np1;
        pk1 = 16'h8000;
        repeat (1000) @(negedge clk);
        check("long_once", 32'(np1 - base), 32'd1);
        check("long_key", 32'(key1), 32'hF);
        pk1 = 16'h0;
        wait_release(1'b0, 80, "long_rel");
        repeat (20) @(negedge clk);
        pk1 = 16'h8000;
        wait_pulse(1'b0, 70, "repress_pulse");
        repeat (20) @(negedge clk);
        base = np1;
        pk1 = 16'h0;
        repeat (16) @(negedge clk);
        pk1 = 16'h8000;
        repeat (100) @(negedge clk);
        check("short_rel_no_pulse", 32'(np1 - base), 32'd0);
        check("short_rel_held", 32'(kh1), 32'd1);

        // Reset while a press of 0x6 is being debounced.
        pk1 = 16'h0;
        wait_release(1'b0, 100, "pre_rst_rel");
        repeat (10) @(negedge clk);
        base = np1;
        pk1 = 16'h0040;
        repeat (32) @(negedge clk);
        check("rst_mid_early", 32'(np1 - base), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_col", 32'(col1), 32'hE);
        check("rst_mid_outs", 32'({key1, kv1, kh1, m1}), 32'h0);
        base = np1;
        repeat (45) @(negedge clk);
        check("rst_mid_not_early", 32'(np1 - base), 32'd0);
        wait_pulse(1'b0, 12, "rst_mid_pulse");
        check("rst_mid_key", 32'(lk1), 32'h6);
        pk1 = 16'h0;

        // Active-high instance, fast scan, single-scan debounce.
        check("hi_onehot_a", 32'($onehot(col2)), 32'd1);
        @(negedge clk);
        check("hi_onehot_b", 32'($onehot(col2)), 32'd1);
        base = np2;
        pk2 = 16'h8000;
        wait_pulse(1'b1, 30, "hi_pulse");
        check("hi_key", 32'(lk2), 32'hF);
        repeat (50) @(negedge clk);
        check("hi_once", 32'(np2 - base), 32'd1);
        check("hi_held", 32'(kh2), 32'd1);
        pk2 = 16'h0;
        wait_release(1'b1, 40, "hi_rel");

        check("no_back_to_back", 32'(consec), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart of the seven-segment output path: scans a 4x4 matrix keypad, debounces it, and emits a 4-bit hex key code with a one-cycle valid strobe.
- Downstream calculator logic consumes the code as a digit or operator.
- The code space 0x0–0xF matches the 16 glyphs the display path renders.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven; rows are sampled on the last cycle of the period. Minimum 3.
- DEBOUNCE_SCANS, 3: consecutive identical full scans required to accept a press or a release. Minimum 1.
- ACTIVE_LOW, 1'b1: 1 means the driven column is low, idle columns are high, and a pressed row reads low. 0 means all of these are inverted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- col  out  4  column drive, one-hot active (polarity per ACTIVE_LOW).
- row  in  4  raw row sense, asynchronous to clk.
- key  out  4  code of the accepted key = {row_index[1:0], col_index[1:0]}.
- key_valid  out  1  one-cycle pulse when a new press is accepted.
- key_held  out  1  high while the accepted key remains down (until release is debounced).
- multi  out  1  high while the last completed scan saw more than one key.

Behaviour:
- Reset. Every register is cleared on a clk edge with rst=1.
  - col drives column 0 active; divider=0; column index=0.
  - key=0, key_valid=0, key_held=0, multi=0.
  - FSM goes to IDLE; debounce count=0; synchronizer flops hold the inactive level.
  - Reset mid-press or mid-debounce discards all history and the scan restarts at column 0.
- Synchronizer.
  - row passes through 2 flops, then is normalized so 1 means pressed.
  - Sampling at divider==SCAN_DIV-1 guarantees at least SCAN_DIV-1 cycles of column settle plus sync latency.
- Scan.
  - The divider counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the 4 normalized row bits are accumulated into the scan result, and the column index advances (3 wraps to 0).
  - col changes on the same edge.
  - One full scan = 4*SCAN_DIV cycles.
- Scan result, classified at the column-3 sample:
  - NONE: zero pressed bits.
  - SINGLE(code): exactly one pressed bit.
  - MULTI: two or more pressed bits.
  - multi updates to (result==MULTI) at the end of each scan.
- Debounce FSM. Evaluated once per completed scan; cnt counts consecutive matching scans.
  - IDLE:
    - SINGLE(c) → CAND, cand=c, cnt=1.
    - Otherwise stay.
  - CAND:
    - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS → PRESSED; key=cand; key_valid=1 for exactly one cycle; key_held=1.
    - SINGLE(other) → restart CAND with the new code, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → REL, cnt=1.
    - SINGLE(same), SINGLE(other), or MULTI → stay. A second key pressed during a hold is ignored, with no new pulse.
  - REL:
    - NONE → cnt+1. When cnt reaches DEBOUNCE_SCANS → IDLE; key_held=0; key keeps its last value.
    - Anything else → PRESSED, with no new pulse.
- DEBOUNCE_SCANS=1:
  - The press is accepted on the same scan-end that enters CAND; no cycle is spent idling in CAND.
  - Release behaves the same way.
- Latency. From rows stable at the pins to the key_valid pulse is 4*SCAN_DIV*DEBOUNCE_SCANS + (at most one partial scan) + 2 sync cycles + 1 cycle.
- key_valid is never asserted on two consecutive cycles. Minimum spacing between pulses is 2*DEBOUNCE_SCANS scans.
- All outputs are registered; there are no combinational paths from row to any output.

Test Plan:
- Clean press. Defaults; after rst, hold row 2 pressed whenever column 1 is driven, for 200 cycles.
  - One key_valid pulse, key=4'h9, within 3 scans + one partial scan + 3 cycles (~66 cycles).
  - key_held=1 until the key is released, and drops 3 full scans after release.
- Bounce. Row 0/column 0 toggles every 5 cycles for 150 cycles, then holds stable.
  - No pulse during bouncing.
  - Exactly one pulse with key=4'h0 within 3 scans of stabilizing.
- Two keys. Keys at row1/col0 and row3/col2 pressed together.
  - multi=1 after the first complete scan.
  - key_valid never pulses; key_held stays 0.
  - Releasing one key leaves a single key, which produces one pulse: key=4'h4 or 4'hE as applicable.
- Long hold / repeat. Hold 4'hF for 1000 cycles → exactly one pulse. Release 3+ scans, press again → second pulse. Release only 1 scan then re-press → no second pulse.
- Reset mid-debounce. Press 4'h6, assert rst for 1 cycle after 2 scans.
  - All outputs 0 and col=column 0 on the next cycle.
  - The pulse arrives 3 full scans after reset deassertion, not earlier.
- Polarity. ACTIVE_LOW=0, SCAN_DIV=3, DEBOUNCE_SCANS=1.
  - col is one-hot high.
  - Pressing row3/col3 with the row high gives one pulse, key=4'hF, within 2 scans.
